instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch (IF) stage of the baseline 5-stage RISC-V ALU pipeline. It produces the IF/ID pipeline register (`instruction_1`, `PC_1`, `prev_taken_1`) that the decode stage consumes, and obeys decode's load-use hold. It drives the instruction cache and predicts control flow: JAL is always taken, BEQ/BNE use a 2-bit bimodal table, and JALR is predicted not-taken. Branch resolution from EX triggers redirect and `flush`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `BHT_IDX_W`, 4, log2 of predictor entries; index = PC[BHT_IDX_W+1:2]

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ICACHE_ren`  out  1  fetch request
- `ICACHE_addr`  out  32  fetch address = current PC
- `ICACHE_rdata`  in  32  instruction word, valid same cycle when `ICACHE_stall`=0
- `ICACHE_stall`  in  1  I-cache miss in progress
- `memory_stall`  in  1  global D-cache stall; freezes the whole pipeline
- `load_use_hazard`  in  1  decode's PC_write; 1 = hold PC and IF/ID
- `resolve_valid`  in  1  EX has resolved a branch/jump this cycle
- `resolve_cond`  in  1  resolved instruction is BEQ/BNE (trains predictor)
- `resolve_PC`  in  32  PC of resolved instruction
- `resolve_taken`  in  1  actual direction
- `resolve_mispredict`  in  1  prediction was wrong
- `resolve_target`  in  32  correct next PC
- `flush`  out  1  kill instruction currently in decode (combinational)
- `instruction_1`  out  32  IF/ID instruction
- `PC_1`  out  32  IF/ID PC
- `prev_taken_1`  out  1  IF/ID predicted-taken flag

## Operation
- Pre-decode of `ICACHE_rdata`:
  - JAL (opcode[6:5]=11, [3:2]=11): taken, target PC + J-imm.
  - BEQ/BNE ([6:5]=11, [3:2]=00): taken iff BHT[idx(PC)][1]; target PC + B-imm.
  - JALR and all other instructions: next = PC+4, not taken.
  - Immediates are sign-extended; additions are mod 2^32.
- `accept` = `resolve_valid` & ~`memory_stall`. `flush` = `accept` & `resolve_mispredict`.
- BHT training, when `accept` & `resolve_cond`:
  - Entry idx(`resolve_PC`) increments if taken, decrements otherwise, saturating at 00 and 11.
  - A same-cycle read of the same entry returns the old value.
- FSM states:
  - NORMAL.
  - REDIRECT_WAIT: a pending target is latched; entered when `flush` occurs while `ICACHE_stall`=1.
- PC update, in priority order:
  1. `memory_stall`: hold.
  2. `flush`: if `ICACHE_stall`, hold PC, latch `resolve_target`, go to REDIRECT_WAIT; else PC ← `resolve_target`.
  3. REDIRECT_WAIT: hold while `ICACHE_stall`; when it drops, PC ← latched target, discard the returned word, go to NORMAL.
  4. `load_use_hazard` or `ICACHE_stall`: hold.
  5. Otherwise PC ← predicted next.
- IF/ID update, in priority order:
  1. `memory_stall`: hold.
  2. `flush`: load NOP.
  3. REDIRECT_WAIT: load NOP.
  4. `load_use_hazard`: hold.
  5. `ICACHE_stall`: load NOP.
  6. Otherwise load {`ICACHE_rdata`, PC, predicted_taken}.
- NOP = 32'h0000_0013, `PC_1`=0, `prev_taken_1`=0.
- A `flush` arriving while already in REDIRECT_WAIT overwrites the latched target.
- `ICACHE_ren` = ~`rst`; it stays 1 during stalls.

## Timing
- Reset (asynchronous):
  - PC = `RESET_PC`, `ICACHE_addr` = `RESET_PC`, `ICACHE_ren` = 0.
  - `instruction_1` = NOP, `PC_1` = 0, `prev_taken_1` = 0, `flush` = 0.
  - FSM = NORMAL, all BHT entries = 2'b01.
  - Reset in mid-redirect drops the pending target.
- Fetch-to-IF/ID latency: 1 cycle. Redirect latency: `ICACHE_addr` = `resolve_target` the cycle after `flush` (no I-miss).
- `flush` is combinational in the same cycle as `accept`. Wrong-path kill is 2 instructions: decode via `flush`, IF/ID via NOP.
- Simultaneous `flush` and `load_use_hazard`: `flush` wins.
- Simultaneous `memory_stall` and anything: everything holds, and BHT does not update.

## Test plan
- Reset, then `ICACHE_rdata` = addi words with no stalls → `ICACHE_addr` 0,4,8,C; `PC_1` trails by one cycle; `prev_taken_1`=0.
- JAL at PC 0x10 with offset +0x20 → next `ICACHE_addr`=0x30; `instruction_1`=JAL, `PC_1`=0x10, `prev_taken_1`=1.
- BEQ at 0x40 with offset −8:
  - First fetch → next 0x44.
  - Two accepted resolves (taken, cond) for 0x40 move the counter 01→10→11.
  - Refetching 0x40 → next 0x38, `prev_taken_1`=1.
  - Four not-taken resolves → counter saturates at 00.
- `resolve_valid`=1, mispredict, target 0x100, no I-miss → `flush`=1 that cycle; next cycle `instruction_1`=0x13 and `ICACHE_addr`=0x100.
- Mispredict (target 0x200) while `ICACHE_stall`=1 for 3 cycles:
  - `ICACHE_addr` holds and the FSM is in REDIRECT_WAIT.
  - When the stall drops, the word is discarded, `instruction_1`=NOP, and next `ICACHE_addr`=0x200.
- `memory_stall`=1 concurrent with a mispredict → `flush`=0, PC/IF/ID/BHT unchanged.
- `load_use_hazard`=1 for 1 cycle → PC and IF/ID hold exactly one cycle, then resume.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: drives the I-cache, predicts the next PC (JAL taken, BEQ/BNE via a
// 2-bit bimodal table) and fills the IF/ID register, with EX-driven redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ICACHE_ren,
  output logic [31:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall,
  input  logic        memory_stall,
  input  logic        load_use_hazard,
  input  logic        resolve_valid,
  input  logic        resolve_cond,
  input  logic [31:0] resolve_PC,
  input  logic        resolve_taken,
  input  logic        resolve_mispredict,
  input  logic [31:0] resolve_target,
  output logic        flush,
  output logic [31:0] instruction_1,
  output logic [31:0] PC_1,
  output logic        prev_taken_1
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned BHT_N = 1 << BHT_IDX_W;

  typedef enum logic {NORMAL, REDIRECT_WAIT} state_t;

  state_t                 state, state_nxt;
  logic [31:0]            pc, pc_nxt;
  logic [31:0]            pend_target, pend_nxt;
  logic [31:0]            instr_nxt, pc1_nxt;
  logic                   pt_nxt;
  logic [1:0]             bht [BHT_N];
  logic [BHT_IDX_W-1:0]   rd_idx, wr_idx;
  logic                   accept;
  logic                   is_jal, is_br, pred_taken;
  logic [31:0]            j_imm, b_imm, pred_next;
  logic                   unused_resolve_pc;

  assign ICACHE_ren  = ~rst;
  assign ICACHE_addr = pc;
  assign accept      = resolve_valid & ~memory_stall;
  assign flush       = accept & resolve_mispredict;
  assign rd_idx      = pc[BHT_IDX_W+1:2];
  assign wr_idx      = resolve_PC[BHT_IDX_W+1:2];
  assign unused_resolve_pc = ^{resolve_PC[31:BHT_IDX_W+2], resolve_PC[1:0]};

  always_comb begin
    is_jal     = (ICACHE_rdata[6:5] == 2'b11) && (ICACHE_rdata[3:2] == 2'b11);
    is_br      = (ICACHE_rdata[6:5] == 2'b11) && (ICACHE_rdata[3:2] == 2'b00);
    j_imm      = {{12{ICACHE_rdata[31]}}, ICACHE_rdata[19:12], ICACHE_rdata[20],
                  ICACHE_rdata[30:21], 1'b0};
    b_imm      = {{20{ICACHE_rdata[31]}}, ICACHE_rdata[7], ICACHE_rdata[30:25],
                  ICACHE_rdata[11:8], 1'b0};
    pred_taken = is_jal | (is_br & bht[rd_idx][1]);
    if (is_jal)          pred_next = pc + j_imm;
    else if (pred_taken) pred_next = pc + b_imm;
    else                 pred_next = pc + 32'd4;
  end

  // PC and IF/ID share one priority chain; REDIRECT_WAIT outranks load-use.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_target;
    instr_nxt = instruction_1;
    pc1_nxt   = PC_1;
    pt_nxt    = prev_taken_1;
    if (memory_stall) begin
      state_nxt = state;
    end else if (flush) begin
      instr_nxt = NOP;
      pc1_nxt   = '0;
      pt_nxt    = 1'b0;
      if (ICACHE_stall) begin
        pend_nxt  = resolve_target;
        state_nxt = REDIRECT_WAIT;
      end else begin
        pc_nxt    = resolve_target;
        state_nxt = NORMAL;
      end
    end else if (state == REDIRECT_WAIT) begin
      instr_nxt = NOP;
      pc1_nxt   = '0;
      pt_nxt    = 1'b0;
      if (!ICACHE_stall) begin
        pc_nxt    = pend_target;
        state_nxt = NORMAL;
      end
    end else if (load_use_hazard) begin
      state_nxt = state;
    end else if (ICACHE_stall) begin
      instr_nxt = NOP;
      pc1_nxt   = '0;
      pt_nxt    = 1'b0;
    end else begin
      pc_nxt    = pred_next;
      instr_nxt = ICACHE_rdata;
      pc1_nxt   = pc;
      pt_nxt    = pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= NORMAL;
      pc            <= RESET_PC;
      pend_target   <= '0;
      instruction_1 <= NOP;
      PC_1          <= '0;
      prev_taken_1  <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      pend_target   <= pend_nxt;
      instruction_1 <= instr_nxt;
      PC_1          <= pc1_nxt;
      prev_taken_1  <= pt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bht <= '{default: 2'b01};
    end else if (accept && resolve_cond) begin
      if (resolve_taken && bht[wr_idx] != 2'b11)
        bht[wr_idx] <= bht[wr_idx] + 2'b01;
      else if (!resolve_taken && bht[wr_idx] != 2'b00)
        bht[wr_idx] <= bht[wr_idx] - 2'b01;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, JAL, bimodal
// training/saturation, redirects with and without I-miss, stalls and reset.
module tb_instruction_fetch;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] JAL  = 32'h0200_00EF;  // jal x1, +0x20
  localparam logic [31:0] BEQ  = 32'hFE00_0CE3;  // beq x0, x0, -8
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ICACHE_ren;
  logic [31:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;
  logic        memory_stall;
  logic        load_use_hazard;
  logic        resolve_valid;
  logic        resolve_cond;
  logic [31:0] resolve_PC;
  logic        resolve_taken;
  logic        resolve_mispredict;
  logic [31:0] resolve_target;
  logic        flush;
  logic [31:0] instruction_1;
  logic [31:0] PC_1;
  logic        prev_taken_1;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .BHT_IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .ICACHE_ren(ICACHE_ren), .ICACHE_addr(ICACHE_addr),
    .ICACHE_rdata(ICACHE_rdata), .ICACHE_stall(ICACHE_stall),
    .memory_stall(memory_stall), .load_use_hazard(load_use_hazard),
    .resolve_valid(resolve_valid), .resolve_cond(resolve_cond),
    .resolve_PC(resolve_PC), .resolve_taken(resolve_taken),
    .resolve_mispredict(resolve_mispredict), .resolve_target(resolve_target),
    .flush(flush), .instruction_1(instruction_1), .PC_1(PC_1),
    .prev_taken_1(prev_taken_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_res();
    resolve_valid      = 1'b0;
    resolve_cond       = 1'b0;
    resolve_PC         = '0;
    resolve_taken      = 1'b0;
    resolve_mispredict = 1'b0;
    resolve_target     = '0;
  endtask

  task automatic set_flush(input logic [31:0] tgt);
    resolve_valid      = 1'b1;
    resolve_cond       = 1'b0;
    resolve_mispredict = 1'b1;
    resolve_target     = tgt;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    set_flush(tgt);
    tick();
    clr_res();
  endtask

  task automatic train(input int n, input logic taken);
    ICACHE_rdata       = ADDI;
    resolve_valid      = 1'b1;
    resolve_cond       = 1'b1;
    resolve_PC         = 32'h40;
    resolve_taken      = taken;
    resolve_mispredict = 1'b0;
    repeat (n) tick();
    clr_res();
  endtask

  // Fetch the BEQ at 0x40 and check the predicted direction.
  task automatic probe(input string tag, input logic exp_taken);
    redirect(32'h40);
    ICACHE_rdata = BEQ;
    tick();
    check({tag, "_addr"}, ICACHE_addr, exp_taken ? 32'h38 : 32'h44);
    check({tag, "_pt"}, {31'b0, prev_taken_1}, {31'b0, exp_taken});
    check({tag, "_pc1"}, PC_1, 32'h40);
    ICACHE_rdata = ADDI;
  endtask

  initial begin
    rst = 1'b1;
    ICACHE_rdata = ADDI;
    ICACHE_stall = 1'b0;
    memory_stall = 1'b0;
    load_use_hazard = 1'b0;
    clr_res();
    #2;
    check("rst_addr", ICACHE_addr, 32'h0);
    check("rst_ren", {31'b0, ICACHE_ren}, 32'h0);
    check("rst_instr", instruction_1, NOP);
    check("rst_pc1", PC_1, 32'h0);
    check("rst_pt", {31'b0, prev_taken_1}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ren_on", {31'b0, ICACHE_ren}, 32'h1);

    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_addr", ICACHE_addr, 32'(4 * i));
      check("seq_pc1", PC_1, 32'(4 * (i - 1)));
    end
    check("seq_instr", instruction_1, ADDI);
    check("seq_pt", {31'b0, prev_taken_1}, 32'h0);

    ICACHE_rdata = JAL;
    tick();
    check("jal_addr", ICACHE_addr, 32'h30);
    check("jal_instr", instruction_1, JAL);
    check("jal_pc1", PC_1, 32'h10);
    check("jal_pt", {31'b0, prev_taken_1}, 32'h1);

    ICACHE_rdata = ADDI;
    set_flush(32'h100);
    #1;
    check("flush_hi", {31'b0, flush}, 32'h1);
    tick();
    clr_res();
    #1;
    check("flush_lo", {31'b0, flush}, 32'h0);
    check("flush_instr", instruction_1, NOP);
    check("flush_pc1", PC_1, 32'h0);
    check("flush_addr", ICACHE_addr, 32'h100);

    probe("bht_init", 1'b0);
    train(2, 1'b1);
    probe("bht_11", 1'b1);
    train(1, 1'b1);
    train(1, 1'b0);
    probe("bht_sat_hi", 1'b1);
    train(4, 1'b0);
    probe("bht_sat_lo", 1'b0);
    train(1, 1'b1);
    probe("bht_01", 1'b0);

    memory_stall       = 1'b1;
    resolve_valid      = 1'b1;
    resolve_cond       = 1'b1;
    resolve_PC         = 32'h40;
    resolve_taken      = 1'b1;
    resolve_mispredict = 1'b1;
    resolve_target     = 32'h300;
    #1;
    check("mst_flush", {31'b0, flush}, 32'h0);
    tick();
    tick();
    check("mst_addr", ICACHE_addr, 32'h44);
    check("mst_instr", instruction_1, BEQ);
    check("mst_pc1", PC_1, 32'h40);
    clr_res();
    memory_stall = 1'b0;
    probe("mst_bht", 1'b0);
    train(1, 1'b1);
    probe("bht_10", 1'b1);

    // Counter is 10: a same-cycle not-taken update must not affect this read.
    redirect(32'h40);
    ICACHE_rdata  = BEQ;
    resolve_valid = 1'b1;
    resolve_cond  = 1'b1;
    resolve_PC    = 32'h40;
    tick();
    clr_res();
    check("rdwr_old", ICACHE_addr, 32'h38);
    probe("rdwr_new", 1'b0);

    redirect(32'h40);
    ICACHE_stall = 1'b1;
    set_flush(32'h200);
    #1;
    check("rw_flush", {31'b0, flush}, 32'h1);
    tick();
    clr_res();
    check("rw_addr0", ICACHE_addr, 32'h40);
    check("rw_instr0", instruction_1, NOP);
    tick();
    check("rw_addr1", ICACHE_addr, 32'h40);
    tick();
    check("rw_addr2", ICACHE_addr, 32'h40);
    ICACHE_stall = 1'b0;
    tick();
    check("rw_addr3", ICACHE_addr, 32'h200);
    check("rw_discard", instruction_1, NOP);
    check("rw_pc1", PC_1, 32'h0);
    tick();
    check("rw_resume", ICACHE_addr, 32'h204);
    check("rw_resume_pc1", PC_1, 32'h200);

    ICACHE_stall = 1'b1;
    redirect(32'h300);
    redirect(32'h340);
    ICACHE_stall = 1'b0;
    tick();
    check("rw_overwrite", ICACHE_addr, 32'h340);
    tick();
    check("lu_pre", ICACHE_addr, 32'h344);

    load_use_hazard = 1'b1;
    tick();
    check("lu_addr", ICACHE_addr, 32'h344);
    check("lu_pc1", PC_1, 32'h340);
    check("lu_instr", instruction_1, ADDI);
    load_use_hazard = 1'b0;
    tick();
    check("lu_go_addr", ICACHE_addr, 32'h348);
    check("lu_go_pc1", PC_1, 32'h344);

    ICACHE_stall = 1'b1;
    tick();
    check("ist_addr", ICACHE_addr, 32'h348);
    check("ist_instr", instruction_1, NOP);
    ICACHE_stall = 1'b0;

    load_use_hazard = 1'b1;
    redirect(32'h400);
    load_use_hazard = 1'b0;
    check("fl_lu_addr", ICACHE_addr, 32'h400);
    check("fl_lu_instr", instruction_1, NOP);

    ICACHE_stall = 1'b1;
    redirect(32'h500);
    #2;
    rst = 1'b1;
    #1;
    check("arst_addr", ICACHE_addr, 32'h0);
    check("arst_ren", {31'b0, ICACHE_ren}, 32'h0);
    check("arst_instr", instruction_1, NOP);
    @(negedge clk);
    rst = 1'b0;
    ICACHE_stall = 1'b0;
    tick();
    check("arst_nopend", ICACHE_addr, 32'h4);
    check("arst_instr2", instruction_1, ADDI);
    check("arst_pc1", PC_1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
